// File: rtl/pfu_pkg.sv
// Prefetch unit shared types and constants.
// Optional feature macro (see pfu.sv): PFU_BYPASS_EN.
// The riscv_defs macros are guarded so this file also builds without the shared header.
`ifndef SOFID_RANGE
`define SOFID_RANGE 1:0
`endif
`ifndef SOFID_RUN
`define SOFID_RUN 2'b00
`endif
`ifndef SOFID_JUMP
`define SOFID_JUMP 2'b01
`endif
`ifndef RV_XLEN
`define RV_XLEN 32
`endif

package pfu_pkg;

  localparam int unsigned Xlen = `RV_XLEN;

  typedef logic [`SOFID_RANGE] sofid_t;

  localparam sofid_t SofidRun  = `SOFID_RUN;
  localparam sofid_t SofidJump = `SOFID_JUMP;

  // One buffered fetch as presented to the ID stage.
  typedef struct packed {
    logic [Xlen-1:0] ins;
    logic            ferr;
    logic [31:0]     pc;
    sofid_t          sofid;
  } fetch_entry_t;

  localparam int unsigned EntryW = $bits(fetch_entry_t);

  function automatic logic [31:0] word_align(logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pfu_if.sv
// Prefetch unit boundary: ID-stage handshake, EX redirect and instruction bus.
// Signal names are from the prefetch unit's point of view (master side).
interface pfu_if;
  import pfu_pkg::*;

  logic            ids_dav_o;
  logic            ids_ack_i;
  sofid_t          ids_sofid_o;
  logic [Xlen-1:0] ids_ins_o;
  logic            ids_ferr_o;
  logic [31:0]     ids_pc_o;

  logic            exs_jump_i;
  logic [31:0]     exs_jump_addr_i;

  logic            ireq_valid_o;
  logic            ireq_ready_i;
  logic [31:0]     ireq_addr_o;
  logic            irsp_valid_i;
  logic            irsp_err_i;
  logic [Xlen-1:0] irsp_data_i;

  modport master (
    output ids_dav_o, ids_sofid_o, ids_ins_o, ids_ferr_o, ids_pc_o,
    input  ids_ack_i, exs_jump_i, exs_jump_addr_i,
    output ireq_valid_o, ireq_addr_o,
    input  ireq_ready_i, irsp_valid_i, irsp_err_i, irsp_data_i
  );

  modport slave (
    input  ids_dav_o, ids_sofid_o, ids_ins_o, ids_ferr_o, ids_pc_o,
    output ids_ack_i, exs_jump_i, exs_jump_addr_i,
    input  ireq_valid_o, ireq_addr_o,
    output ireq_ready_i, irsp_valid_i, irsp_err_i, irsp_data_i
  );

endinterface

// File: rtl/pfu_fifo.sv
// Synchronous Depth x Width FIFO with flush. Storage resets to ResetVal so the head
// output has a defined value before the first write.
module pfu_fifo #(
  parameter int unsigned      Depth    = 4,
  parameter int unsigned      Width    = 8,
  parameter logic [Width-1:0] ResetVal = '0,
  localparam int unsigned     AddrW    = $clog2(Depth),
  localparam int unsigned     CntW     = AddrW + 1
) (
  input  logic             clk_i,
  input  logic             resetb_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ((count_q != CntW'(Depth)) | do_pop);

  // Pointer and occupancy update; flush wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= ResetVal;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/pfu.sv
// Prefetch unit: credit-limited in-order instruction fetch into a small buffer feeding ID.
// Optional feature macro: PFU_BYPASS_EN (an undiscarded response into an empty buffer is
// shown to ID combinationally in the same cycle).
module pfu import pfu_pkg::*; #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic  clk_i,
  input  logic  resetb_i,
  input  logic  clk_en_i,
  pfu_if.master pfu_io
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] CreditMax = (CntW + 1)'(DEPTH);
  localparam fetch_entry_t HeadReset = '{ins: '0, ferr: 1'b0, pc: RESET_ADDR, sofid: SofidJump};

  logic            started_q;
  logic [31:0]     req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d;
  logic            sof_pending_q, sof_pending_d;
  logic [CntW-1:0] outst_q, outst_d, discard_q, discard_d, fifo_count;
  logic            fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic            req_valid, req_hs, rsp_live, byp_vld, byp_taken;
  fetch_entry_t    rsp_entry, head_entry, ids_entry;

  // Credit: buffered plus in-flight words never exceed the buffer size.
  assign req_valid = started_q & (({1'b0, fifo_count} + {1'b0, outst_q}) < CreditMax);
  assign req_hs    = req_valid & pfu_io.ireq_ready_i;
  assign rsp_live  = pfu_io.irsp_valid_i & (discard_q == '0);

  assign pfu_io.ireq_valid_o = req_valid;
  assign pfu_io.ireq_addr_o  = req_pc_q;

  assign rsp_entry = '{ins:   pfu_io.irsp_data_i,
                       ferr:  pfu_io.irsp_err_i,
                       pc:    rsp_pc_q,
                       sofid: sof_pending_q ? SofidJump : SofidRun};

`ifdef PFU_BYPASS_EN
  // The jump cycle's response is always dropped, so it is never bypassed either.
  assign byp_vld = fifo_empty & rsp_live & ~pfu_io.exs_jump_i;
`else
  assign byp_vld = 1'b0;
`endif

  assign byp_taken  = byp_vld & pfu_io.ids_ack_i;
  assign ids_entry  = byp_vld ? rsp_entry : head_entry;
  assign fifo_pop   = clk_en_i & pfu_io.ids_ack_i & ~fifo_empty;
  assign fifo_push  = clk_en_i & rsp_live & ~pfu_io.exs_jump_i & ~byp_taken;
  assign fifo_flush = clk_en_i & pfu_io.exs_jump_i;

  assign pfu_io.ids_dav_o   = ~fifo_empty | byp_vld;
  assign pfu_io.ids_ins_o   = ids_entry.ins;
  assign pfu_io.ids_ferr_o  = ids_entry.ferr;
  assign pfu_io.ids_pc_o    = ids_entry.pc;
  assign pfu_io.ids_sofid_o = ids_entry.sofid;

  pfu_fifo #(
    .Depth    (DEPTH),
    .Width    (EntryW),
    .ResetVal (HeadReset)
  ) u_fifo (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .push_i   (fifo_push),
    .wdata_i  (rsp_entry),
    .pop_i    (fifo_pop),
    .flush_i  (fifo_flush),
    .count_o  (fifo_count),
    .empty_o  (fifo_empty),
    .head_o   (head_entry)
  );

  // PC, credit and discard next state; a redirect overrides every other update.
  always_comb begin
    req_pc_d      = req_pc_q;
    rsp_pc_d      = rsp_pc_q;
    sof_pending_d = sof_pending_q;
    discard_d     = discard_q;
    outst_d       = outst_q + CntW'(req_hs) - CntW'(pfu_io.irsp_valid_i);
    if (pfu_io.exs_jump_i) begin
      req_pc_d      = word_align(pfu_io.exs_jump_addr_i);
      rsp_pc_d      = word_align(pfu_io.exs_jump_addr_i);
      sof_pending_d = 1'b1;
      // Everything still in flight after this cycle belongs to the old stream.
      discard_d     = outst_d;
    end else begin
      if (req_hs) req_pc_d = req_pc_q + 32'd4;
      if (pfu_io.irsp_valid_i) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CntW'(1);
        end else begin
          rsp_pc_d      = rsp_pc_q + 32'd4;
          sof_pending_d = 1'b0;
        end
      end
    end
  end

  // State registers, frozen while the clock enable is low.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      started_q     <= 1'b0;
      req_pc_q      <= RESET_ADDR;
      rsp_pc_q      <= RESET_ADDR;
      sof_pending_q <= 1'b1;
      outst_q       <= '0;
      discard_q     <= '0;
    end else if (clk_en_i) begin
      started_q     <= 1'b1;
      req_pc_q      <= req_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      sof_pending_q <= sof_pending_d;
      outst_q       <= outst_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: doc/pfu.md
# pfu

Prefetch unit for the rv32i core. It issues in-order 32-bit instruction fetches on the instruction bus and buffers returned words in a small FIFO. It presents them to the ID stage with the dav/ack handshake, tagged with PC, fetch-error flag and start-of-fetch id. It sits directly upstream of id_stage, and the EX stage redirects it on taken jumps, branches and traps.

## Interface
- DEPTH, 4: fetch-buffer entries; power of two, ≥2.
- RESET_ADDR, 32'h0000_0000: first fetch address after reset.

Ports:
- clk_i  in  1  core clock
- resetb_i  in  1  reset; asynchronous, active-low; clock clk_i
- clk_en_i  in  1  global clock enable; no state changes when low
- ids_dav_o  out  1  buffer head valid
- ids_ack_i  in  1  ID consumes head (only meaningful with dav)
- ids_sofid_o  out  `SOFID_RANGE  `SOFID_JUMP on first instruction since reset/vector, else `SOFID_RUN
- ids_ins_o  out  32  instruction word
- ids_ferr_o  out  1  fetch bus error for this word
- ids_pc_o  out  32  address of this word
- exs_jump_i  in  1  vector request
- exs_jump_addr_i  in  32  vector target; bits [1:0] ignored, treated 0
- ireq_valid_o  out  1  fetch request
- ireq_ready_i  in  1  bus accepts request
- ireq_addr_o  out  32  fetch address, word aligned
- irsp_valid_i  in  1  response valid; in order, ≥1 cycle after accept
- irsp_err_i  in  1  response error
- irsp_data_i  in  32  response data

## Operation
- State: req_pc_q, rsp_pc_q, sof_pending_q, started_q, outstanding count, discard count, FIFO (ins, ferr, pc, sofid) with rd/wr pointers and count.
- started_q resets 0 and sets on the first enabled edge.
- ireq_valid_o = started_q & (fifo_count + outstanding < DEPTH). This is credit-based, so the FIFO can never overflow.
- Request handshake (valid & ready): req_pc_q += 4, outstanding += 1.
- Response with discard count = 0: push {data, err, rsp_pc_q, sof_pending_q ? JUMP : RUN}, then rsp_pc_q += 4 and clear sof_pending_q.
- Response with discard count > 0: drop it and decrement discard.
- Each response decrements outstanding.
- ids_ack_i & ids_dav_o pops the head.
- exs_jump_i (priority over all other updates):
  - flush FIFO (count 0)
  - req_pc_q, rsp_pc_q ← target
  - sof_pending_q ← 1
  - discard ← outstanding (+1 if a request handshakes this cycle, −1 if a response arrives this cycle); that cycle's response is always dropped
  - a pop in the jump cycle still completes; ID has already taken that word
- Errors are not retried; the fetch stream continues sequentially.
- Addresses wrap modulo 2^32.

## Timing
- Reset values:
  - ids_dav_o 0, ids_sofid_o `SOFID_JUMP, ids_ins_o 0, ids_ferr_o 0, ids_pc_o RESET_ADDR
  - ireq_valid_o 0, ireq_addr_o RESET_ADDR
  - counts 0, sof_pending_q 1
- First request is on the cycle after reset release (given clk_en_i).
- Response-to-dav latency: 1 cycle (registered FIFO write).
- ireq_addr_o = req_pc_q; combinational from state only, with no comb path from exs_jump_i.
- Full FIFO with ids_ack_i low: no requests issued; responses already in flight are covered by credit.
- Empty FIFO: ids_dav_o 0; head outputs hold the last value (don't care).
- Reset mid-operation: all in-flight state is lost. The bus is reset together with the core.

## Configuration
- PFU_BYPASS_EN:
  - Defined: when the FIFO is empty and an undiscarded response arrives, it drives ids_* combinationally with ids_dav_o=1. If acked that cycle it is not written to the FIFO. Response-to-dav latency is 0.
  - Undefined: all responses pass through the FIFO, giving latency 1 and no comb path bus→ID.

## Structure
- Shared riscv_defs.v: `SOFID_RANGE, `SOFID_RUN, `SOFID_JUMP, `RV_XLEN.
- Sub-module pfu_fifo: parameterised DEPTH×WIDTH synchronous FIFO with push, pop, flush, count, head.
- pfu holds the PC, credit and discard logic.

## Test plan
- Reset release with ready=1 and 1-cycle responses: fetches at 0x0, 0x4, 0x8… The first ID word has pc 0x0 with SOFID_JUMP, then RUN.
- ids_ack_i held 0, DEPTH=4: exactly 4 requests accepted, then ireq_valid_o stays 0. One ack leads to exactly one further request.
- Jump to 0x100 with 2 requests outstanding: the next 2 responses are dropped. The first delivered word has pc 0x100 with SOFID_JUMP.
- Response with irsp_err_i=1 at 0x8: word delivered with ferr=1. The next word, pc 0xC, has ferr=0.
- Jump, response and ack in the same cycle: the acked word is consumed, the response is dropped, and the FIFO is empty the next cycle.
- PFU_BYPASS_EN, empty FIFO, response at 0x20 with ack in the same cycle: dav=1 and pc 0x20 that cycle, and the FIFO count stays 0.
